// File: rtl/br_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg
// Shared types for the branch functional unit.
//   OP_W        : width of the branch/jump opcode field
//   br_op_t     : opcode enum (BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR)
//   br_result_t : resolved-branch record at the core's default widths
//                 (BR_XLEN / BR_TAG_W), for consumers in the default
//                 configuration. branch_resolve_unit builds an identically
//                 ordered record from its own XLEN/TAG_W parameters.
// ---------------------------------------------------------------------------
package br_pkg;

    localparam int OP_W     = 3;
    localparam int BR_XLEN  = 32;
    localparam int BR_TAG_W = 6;

    typedef enum logic [OP_W-1:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLT  = 3'd2,
        OP_BGE  = 3'd3,
        OP_BLTU = 3'd4,
        OP_BGEU = 3'd5,
        OP_JAL  = 3'd6,
        OP_JALR = 3'd7
    } br_op_t;

    typedef struct packed {
        logic [BR_TAG_W-1:0] tag;
        logic                taken;
        logic                mispredict;
        logic                misaligned;
        logic [BR_XLEN-1:0]  redirect;
        logic [BR_XLEN-1:0]  link;
        logic                link_we;
    } br_result_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Small FIFO with a combinational head read, synchronous active-low reset
// and a synchronous flush. Storage is cleared on reset so the head reads 0.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   flush              : drop all entries (priority over push and pop)
//   push, push_data    : write request and payload (ignored when full)
//   pop                : remove head (ignored when empty)
//   head_data          : payload at the head (valid when count != 0)
//   count              : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             full, empty;
    logic             push_ok, pop_ok;
    logic [DEPTH-1:0] wr_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (pop_ok)  rd_ptr_next = ptr_inc(rd_ptr_reg);
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // One write strobe per entry, decoded from the write pointer.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) mem_reg[i] <= push_data;
            end
        end
    end

    // Head is read combinationally so a result is visible the cycle after
    // it is pushed into an empty queue.
    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves RV32I conditional branches and JAL/JALR: direction, target,
// redirect address, link value and mispredict against the fetch prediction.
// Results are queued (sync_fifo) and drained with a valid/ready handshake.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   flush_i                       : kill queued results and same-cycle input
//   valid_i / ready_o             : issue handshake (ready_o = count < DEPTH)
//   op_i, pc_i, imm_i,
//   rs1_val_i, rs2_val_i          : operation and operands
//   pred_taken_i, pred_target_i   : fetch-stage prediction
//   rob_tag_i                     : ROB entry of the instruction
//   valid_o / ready_i             : result handshake toward writeback
//   rob_tag_o, actual_taken_o,
//   mispredict_o, misaligned_o,
//   redirect_addr_o, link_o,
//   link_we_o                     : head-of-queue result fields
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [OP_W-1:0]  op_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [XLEN-1:0]  rs1_val_i,
    input  logic [XLEN-1:0]  rs2_val_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  pred_target_i,
    input  logic [TAG_W-1:0] rob_tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [TAG_W-1:0] rob_tag_o,
    output logic             actual_taken_o,
    output logic             mispredict_o,
    output logic             misaligned_o,
    output logic [XLEN-1:0]  redirect_addr_o,
    output logic [XLEN-1:0]  link_o,
    output logic             link_we_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    // Same field order as br_result_t, sized by this instance's parameters.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic             mispredict;
        logic             misaligned;
        logic [XLEN-1:0]  redirect;
        logic [XLEN-1:0]  link;
        logic             link_we;
    } result_t;

    localparam int RES_W = $bits(result_t);

    br_op_t           op;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target;
    logic             taken;
    logic             link_we;
    logic             accept;
    result_t          res;
    result_t          head;
    logic [RES_W-1:0] head_data;
    logic [CNT_W-1:0] count;

    assign op        = br_op_t'(op_i);
    assign pc_plus4  = pc_i + XLEN'(4);
    assign br_target = pc_i + imm_i;
    assign jalr_sum  = rs1_val_i + imm_i;

    always_comb begin
        taken   = 1'b0;
        link_we = 1'b0;
        target  = br_target;
        case (op)
            OP_BEQ:  taken = (rs1_val_i == rs2_val_i);
            OP_BNE:  taken = (rs1_val_i != rs2_val_i);
            OP_BLT:  taken = ($signed(rs1_val_i) <  $signed(rs2_val_i));
            OP_BGE:  taken = ($signed(rs1_val_i) >= $signed(rs2_val_i));
            OP_BLTU: taken = (rs1_val_i <  rs2_val_i);
            OP_BGEU: taken = (rs1_val_i >= rs2_val_i);
            OP_JAL: begin
                taken   = 1'b1;
                link_we = 1'b1;
            end
            OP_JALR: begin
                taken   = 1'b1;
                link_we = 1'b1;
                target  = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: begin
                taken   = 1'b0;
                link_we = 1'b0;
            end
        endcase
    end

    always_comb begin
        res.tag        = rob_tag_i;
        res.taken      = taken;
        // Target only matters for the mispredict when both sides say taken.
        res.mispredict = (taken != pred_taken_i) ||
                         (taken && pred_taken_i && (target != pred_target_i));
        res.misaligned = taken && (target[1:0] != 2'b00);
        res.redirect   = taken ? target : pc_plus4;
        res.link       = pc_plus4;
        res.link_we    = link_we;
    end

    assign ready_o = (count < CNT_W'(DEPTH));
    assign valid_o = (count != '0);
    assign accept  = valid_i && ready_o && !flush_i;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_i),
        .push      (accept),
        .push_data (res),
        .pop       (valid_o && ready_i),
        .head_data (head_data),
        .count     (count)
    );

    assign head            = result_t'(head_data);
    assign rob_tag_o       = head.tag;
    assign actual_taken_o  = head.taken;
    assign mispredict_o    = head.mispredict;
    assign misaligned_o    = head.misaligned;
    assign redirect_addr_o = head.redirect;
    assign link_o          = head.link;
    assign link_we_o       = head.link_we;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Scoreboard bench: the driver pushes expected results when an issue is
// accepted; a negedge monitor compares the queue head against the DUT.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;
    import br_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n, flush_i, valid_i, ready_o, ready_i, valid_o;
    logic [2:0]       op_i;
    logic [XLEN-1:0]  pc_i, imm_i, rs1_val_i, rs2_val_i, pred_target_i;
    logic             pred_taken_i;
    logic [TAG_W-1:0] rob_tag_i, rob_tag_o;
    logic             actual_taken_o, mispredict_o, misaligned_o, link_we_o;
    logic [XLEN-1:0]  redirect_addr_o, link_o;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .op_i(op_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs1_val_i(rs1_val_i), .rs2_val_i(rs2_val_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .rob_tag_i(rob_tag_i), .valid_o(valid_o), .ready_i(ready_i),
        .rob_tag_o(rob_tag_o), .actual_taken_o(actual_taken_o),
        .mispredict_o(mispredict_o), .misaligned_o(misaligned_o),
        .redirect_addr_o(redirect_addr_o), .link_o(link_o),
        .link_we_o(link_we_o)
    );

    typedef struct {
        logic [2:0]       op;
        logic [XLEN-1:0]  pc, imm, a, b, ptgt;
        logic             pt;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             taken, mis, misal, lwe;
        logic [XLEN-1:0]  redir, link;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    bit   started = 0;
    int   rmode   = 1;   // 0: ready_i low, 1: high, 2: random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model straight from the ISA rules.
    function automatic exp_t model(input req_t r);
        exp_t e;
        logic [XLEN-1:0] tgt;
        logic t;
        tgt = r.pc + r.imm;
        t   = 1'b0;
        case (r.op)
            3'd0: t = (r.a == r.b);
            3'd1: t = (r.a != r.b);
            3'd2: t = ($signed(r.a) <  $signed(r.b));
            3'd3: t = ($signed(r.a) >= $signed(r.b));
            3'd4: t = (r.a <  r.b);
            3'd5: t = (r.a >= r.b);
            3'd6: t = 1'b1;
            default: begin
                t   = 1'b1;
                tgt = (r.a + r.imm) & 32'hFFFF_FFFE;
            end
        endcase
        e.tag   = r.tag;
        e.taken = t;
        e.redir = t ? tgt : r.pc + 32'd4;
        e.mis   = (t != r.pt) || (t && r.pt && (tgt != r.ptgt));
        e.misal = t && ((tgt % 4) != 0);
        e.link  = r.pc + 32'd4;
        e.lwe   = (r.op >= 3'd6);
        return e;
    endfunction

    function automatic exp_t mk(input logic [TAG_W-1:0] tag, input logic t, input logic mis,
                                input logic misal, input logic [XLEN-1:0] redir,
                                input logic [XLEN-1:0] link, input logic lwe);
        exp_t e;
        e.tag = tag; e.taken = t; e.mis = mis; e.misal = misal;
        e.redir = redir; e.link = link; e.lwe = lwe;
        return e;
    endfunction

    function automatic req_t mkreq(input logic [2:0] op, input logic [XLEN-1:0] pc,
                                   input logic [XLEN-1:0] imm, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic pt,
                                   input logic [XLEN-1:0] ptgt, input logic [TAG_W-1:0] tag);
        req_t r;
        r.op = op; r.pc = pc; r.imm = imm; r.a = a; r.b = b;
        r.pt = pt; r.ptgt = ptgt; r.tag = tag;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        logic [12:0] s;
        s      = 13'($urandom);
        r.op   = 3'($urandom_range(0, 7));
        r.pc   = $urandom & 32'hFFFF_FFFC;
        r.imm  = {{19{s[12]}}, s};
        r.a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) - 32'd2 : $urandom;
        r.b    = ($urandom_range(0, 3) == 0) ? r.a : $urandom;
        r.pt   = 1'($urandom_range(0, 1));
        r.ptgt = ($urandom_range(0, 1) == 1) ? r.pc + r.imm : $urandom;
        r.tag  = TAG_W'($urandom);
        return r;
    endfunction

    task automatic set_ready();
        case (rmode)
            0:       ready_i = 1'b0;
            1:       ready_i = 1'b1;
            default: ready_i = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic drive_req(input req_t r);
        op_i = r.op; pc_i = r.pc; imm_i = r.imm; rs1_val_i = r.a; rs2_val_i = r.b;
        pred_taken_i = r.pt; pred_target_i = r.ptgt; rob_tag_i = r.tag;
    endtask

    // One cycle of issue; the expected result is queued if accepted.
    task automatic try_issue(input req_t r, input exp_t e, output bit acc);
        @(posedge clk); #1;
        valid_i = 1'b1; flush_i = 1'b0;
        drive_req(r);
        set_ready();
        #1;
        check("ready_o", ready_o, sb.size() < DEPTH);
        acc = ready_o;
        @(negedge clk); #1;
        if (acc) sb.push_back(e);
    endtask

    task automatic issue(input req_t r, input exp_t e);
        bit acc;
        int tries;
        acc = 0;
        tries = 0;
        while (!acc && tries < 100) begin
            try_issue(r, e, acc);
            tries++;
        end
        if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: got not-accepted expected accepted");
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        set_ready();
        #1;
        check("ready_o_idle", ready_o, sb.size() < DEPTH);
    endtask

    task automatic do_flush();
        @(posedge clk); #1;
        valid_i = 1'b1; flush_i = 1'b1;
        drive_req(rand_req());
        set_ready();
        @(negedge clk); #1;
        sb.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        rmode = 1;
        while (sb.size() != 0 && n < 50) begin
            idle();
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d left expected 0", sb.size());
        end
    endtask

    // Monitor: head must match the oldest outstanding expectation every cycle
    // it is presented; it is retired when the consumer takes it.
    always @(negedge clk) begin : mon
        exp_t e;
        if (started && rst_n) begin
            check("valid_o", valid_o, sb.size() != 0);
            if (valid_o && sb.size() != 0) begin
                e = sb[0];
                check("rob_tag", rob_tag_o, e.tag);
                check("taken", actual_taken_o, e.taken);
                check("mispredict", mispredict_o, e.mis);
                check("misaligned", misaligned_o, e.misal);
                check("redirect", redirect_addr_o, e.redir);
                check("link", link_o, e.link);
                check("link_we", link_we_o, e.lwe);
                if (ready_i) begin
                    $display("pop tag=%0h taken=%0b mis=%0b redirect=%0h", e.tag, e.taken, e.mis, e.redir);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        req_t r;
        rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        drive_req(mkreq(3'd0, 0, 0, 0, 0, 1'b0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_ready_o", ready_o, 1'b1);
        check("rst_redirect", redirect_addr_o, 0);
        check("rst_link", link_o, 0);
        check("rst_tag", rob_tag_o, 0);
        rst_n = 1'b1;
        started = 1;

        // Directed cases with hand-computed results.
        rmode = 1;
        issue(mkreq(OP_BLT, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 6'd1),
              mk(6'd1, 1'b1, 1'b1, 1'b0, 32'h120, 32'h104, 1'b0));
        issue(mkreq(OP_BLTU, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 6'd2),
              mk(6'd2, 1'b0, 1'b0, 1'b0, 32'h104, 32'h104, 1'b0));
        issue(mkreq(OP_JALR, 32'h200, 32'h0, 32'h1003, 32'd0, 1'b1, 32'h1000, 6'd3),
              mk(6'd3, 1'b1, 1'b1, 1'b1, 32'h1002, 32'h204, 1'b1));
        issue(mkreq(OP_BEQ, 32'hFFFF_FFF0, 32'h20, 32'd5, 32'd5, 1'b1, 32'h10, 6'd4),
              mk(6'd4, 1'b1, 1'b0, 1'b0, 32'h10, 32'hFFFF_FFF4, 1'b0));
        drain();

        // Full boundary: two accepts with the consumer stalled, third stalls.
        rmode = 0;
        r = mkreq(OP_JAL, 32'h400, 32'h40, 0, 0, 1'b1, 32'h440, 6'd10);
        try_issue(r, model(r), acc);
        r = mkreq(OP_BNE, 32'h500, 32'hFFFF_FFF0, 1, 2, 1'b0, 0, 6'd11);
        try_issue(r, model(r), acc);
        r = mkreq(OP_BGE, 32'h600, 32'h8, 32'h8000_0000, 0, 1'b0, 0, 6'd12);
        try_issue(r, model(r), acc);
        check("third_stalls", acc, 1'b0);
        rmode = 1;
        issue(r, model(r));
        drain();

        // Flush with two entries queued and a same-cycle input.
        rmode = 0;
        r = rand_req(); issue(r, model(r));
        r = rand_req(); issue(r, model(r));
        do_flush();
        idle();
        check("flush_valid_o", valid_o, 1'b0);
        check("flush_ready_o", ready_o, 1'b1);

        // Reset mid-operation with one entry queued.
        r = rand_req(); issue(r, model(r));
        @(posedge clk); #1;
        valid_i = 1'b0; rst_n = 1'b0;
        @(negedge clk); #1;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_valid_o", valid_o, 1'b0);
        check("mid_rst_ready_o", ready_o, 1'b1);
        check("mid_rst_redirect", redirect_addr_o, 0);
        check("mid_rst_link", link_o, 0);
        check("mid_rst_tag", rob_tag_o, 0);
        check("mid_rst_flags", {actual_taken_o, mispredict_o, misaligned_o, link_we_o}, 4'b0);

        // Randomised traffic with random backpressure and occasional flushes.
        rmode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_flush();
            end else if ($urandom_range(0, 5) == 0) begin
                idle();
            end else begin
                r = rand_req();
                issue(r, model(r));
            end
        end
        drain();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
